// File: rtl/simple_bus_reg_slave.sv
// Target endpoint for the simple_bus request/valid protocol: a byte-wide register
// bank at BASE_ADDR that answers every request with one s_valid pulse after WAIT_STATES idle cycles.
module simple_bus_reg_slave #(
    parameter logic [7:0] BASE_ADDR   = 8'h40,
    parameter int         DEPTH       = 16,
    parameter int         WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_req,
    input  logic       s_rw,
    input  logic [7:0] s_addr,
    input  logic [7:0] s_wdata,
    output logic [7:0] s_rdata,
    output logic       s_valid,
    output logic       busy,
    output logic [1:0] dbg_state
);

    // Handshake: the requester raises s_req with s_rw/s_addr/s_wdata and holds it until
    // it sees s_valid; s_valid is a single-cycle pulse and s_rdata is 8'h00 outside it.
    // A new request is accepted only after s_req has been low for at least one edge.

    localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [8:0] LIM9    = {1'b0, BASE_ADDR} + 9'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             rw_q;
    logic [7:0]       addr_q;
    logic [7:0]       wdata_q;
    logic             valid_q;
    logic [7:0]       rdata_q;
    logic [7:0]       regs_q [DEPTH];
    logic             capture;
    logic             respond;
    logic             hit;
    logic [IDX_W-1:0] idx;

    // 9-bit compare so the upper bound never wraps past 8'hFF
    assign hit = ({1'b0, addr_q} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_q} < LIM9);
    assign idx = IDX_W'(addr_q - BASE_ADDR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        respond = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_req) begin
                    capture = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                respond = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!s_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            valid_q <= 1'b0;
            rdata_q <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                rw_q    <= s_rw;
                addr_q  <= s_addr;
                wdata_q <= s_wdata;
            end
            // The edge leaving RESP raises s_valid, loads read data and commits writes together
            valid_q <= respond;
            rdata_q <= (respond && rw_q && hit) ? regs_q[idx] : 8'h00;
            if (respond && !rw_q && hit) begin
                regs_q[idx] <= wdata_q;
            end
        end
    end

    assign s_valid   = valid_q;
    assign s_rdata   = rdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_simple_bus_reg_slave.sv
// Bench for simple_bus_reg_slave: three instances (WAIT_STATES 1, 0, 3) sharing the bus
// data lines, each with its own s_req, checked against a table and an address-map model.
module tb_simple_bus_reg_slave;

  localparam int BASE  = 8'h40;
  localparam int DEPTH = 16;

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       req [3];
  logic       bus_rw;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] rdata [3];
  logic       valid [3];
  logic       busy [3];
  logic [1:0] dbg [3];

  int vectors;
  int miscompares;
  logic [7:0] mem [3][256];

  simple_bus_reg_slave #(.BASE_ADDR(8'h40), .DEPTH(16), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .s_req(req[0]), .s_rw(bus_rw), .s_addr(bus_addr),
    .s_wdata(bus_wdata), .s_rdata(rdata[0]), .s_valid(valid[0]), .busy(busy[0]),
    .dbg_state(dbg[0]));

  simple_bus_reg_slave #(.BASE_ADDR(8'h40), .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .s_req(req[1]), .s_rw(bus_rw), .s_addr(bus_addr),
    .s_wdata(bus_wdata), .s_rdata(rdata[1]), .s_valid(valid[1]), .busy(busy[1]),
    .dbg_state(dbg[1]));

  simple_bus_reg_slave #(.BASE_ADDR(8'h40), .DEPTH(16), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .s_req(req[2]), .s_rw(bus_rw), .s_addr(bus_addr),
    .s_wdata(bus_wdata), .s_rdata(rdata[2]), .s_valid(valid[2]), .busy(busy[2]),
    .dbg_state(dbg[2]));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ws_of(input int k);
    if (k == 0) return 1;
    if (k == 1) return 0;
    return 3;
  endfunction

  function automatic bit model_hit(input logic [7:0] a);
    return (int'(a) >= BASE) && (int'(a) < BASE + DEPTH);
  endfunction

  function automatic logic [7:0] model_read(input int k, input logic [7:0] a);
    return model_hit(a) ? mem[k][a] : 8'h00;
  endfunction

  task automatic model_write(input int k, input logic [7:0] a, input logic [7:0] d);
    if (model_hit(a)) mem[k][a] = d;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 256; a++)
        mem[k][a] = 8'h00;
  endtask

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // driver: one complete transaction on dut k, starting at a negedge with the DUT idle
  task automatic do_txn(input int k, input logic rw, input logic [7:0] addr,
                        input logic [7:0] wdata, input int hold, input bit early,
                        input logic [7:0] exp_rd);
    int  n;
    bit  seen;
    bus_rw    = rw;
    bus_addr  = addr;
    bus_wdata = wdata;
    req[k]    = 1'b1;
    seen = 0;
    n    = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (valid[k]) begin
        seen = 1;
        check("latency", k, n, ws_of(k) + 1);
        check("rdata", k, rdata[k], exp_rd);
      end else begin
        check("busy_pending", k, busy[k], 1);
        check("rdata_idle", k, rdata[k], 0);
      end
      if (n == 0) begin
        bus_rw    = 1'($urandom_range(0, 1));
        bus_addr  = 8'($urandom_range(0, 255));
        bus_wdata = 8'($urandom_range(0, 255));
        if (early) req[k] = 1'b0;
      end
      n++;
    end
    if (!seen) check("valid_timeout", k, 0, 1);
    if (!early) begin
      repeat (hold) begin
        @(negedge clk);
        check("single_pulse", k, valid[k], 0);
        check("busy_done", k, busy[k], 1);
      end
    end
    req[k] = 1'b0;
    @(negedge clk);
    check("busy_clear", k, busy[k], 0);
    check("valid_after", k, valid[k], 0);
    check("rdata_after", k, rdata[k], 0);
    if (rw) begin
      // the bench keeps the model in step for writes only
    end else begin
      model_write(k, addr, wdata);
    end
  endtask

  vec_t tbl [$];
  logic [7:0] a, d;
  logic       r;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus_rw      = 1'b0;
    bus_addr    = 8'h00;
    bus_wdata   = 8'h00;
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    model_reset();

    tbl.push_back('{1'b0, 8'h42, 8'h37, 8'h00});
    tbl.push_back('{1'b1, 8'h42, 8'h00, 8'h37});
    tbl.push_back('{1'b0, 8'h4F, 8'h5A, 8'h00});
    tbl.push_back('{1'b1, 8'h4F, 8'h00, 8'h5A});
    tbl.push_back('{1'b0, 8'h50, 8'h11, 8'h00});
    tbl.push_back('{1'b0, 8'h3F, 8'h22, 8'h00});
    tbl.push_back('{1'b1, 8'h50, 8'h00, 8'h00});
    tbl.push_back('{1'b1, 8'h3F, 8'h00, 8'h00});
    tbl.push_back('{1'b1, 8'h4F, 8'h00, 8'h5A});
    tbl.push_back('{1'b1, 8'h40, 8'h00, 8'h00});
    tbl.push_back('{1'b1, 8'hA5, 8'h00, 8'h00});
    tbl.push_back('{1'b1, 8'h42, 8'h00, 8'h37});

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_valid", k, valid[k], 0);
      check("reset_rdata", k, rdata[k], 0);
      check("reset_busy", k, busy[k], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // directed table on the WAIT_STATES=1 instance
    foreach (tbl[i]) begin
      do_txn(0, tbl[i].rw, tbl[i].addr, tbl[i].wdata, 0, 0, tbl[i].exp_rdata);
    end

    // request held 4 cycles past s_valid, then an immediate follow-up read
    do_txn(0, 1'b0, 8'h43, 8'h99, 4, 0, 8'h00);
    do_txn(0, 1'b1, 8'h43, 8'h00, 0, 0, 8'h99);

    // s_req dropped during WAIT still completes
    do_txn(0, 1'b0, 8'h44, 8'h7E, 0, 1, 8'h00);
    do_txn(0, 1'b1, 8'h44, 8'h00, 0, 0, 8'h7E);

    // reset while in WAIT of a write
    bus_rw    = 1'b0;
    bus_addr  = 8'h45;
    bus_wdata = 8'hC3;
    req[0]    = 1'b1;
    @(negedge clk);
    check("wait_busy", 0, busy[0], 1);
    rst    = 1'b1;
    req[0] = 1'b0;
    #1;
    check("rst_busy_now", 0, busy[0], 0);
    check("rst_valid_now", 0, valid[0], 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_valid", 0, valid[0], 0);
      check("rst_idle", 0, busy[0], 0);
    end
    do_txn(0, 1'b1, 8'h45, 8'h00, 0, 0, 8'h00);
    do_txn(0, 1'b1, 8'h43, 8'h00, 0, 0, 8'h00);

    // WAIT_STATES 0 and 3: write then back-to-back reads of 0x41
    for (int k = 1; k < 3; k++) begin
      do_txn(k, 1'b0, 8'h41, 8'h6E, 0, 0, 8'h00);
      do_txn(k, 1'b1, 8'h41, 8'h00, 0, 0, 8'h6E);
      do_txn(k, 1'b1, 8'h41, 8'h00, 0, 0, 8'h6E);
    end

    // randomized traffic against the address-map model
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 40; t++) begin
        r = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
        else a = 8'(BASE - 2 + $urandom_range(0, DEPTH + 3));
        d = 8'($urandom_range(0, 255));
        do_txn(k, r, a, d, $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0),
               r ? model_read(k, a) : 8'h00);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
